sram_mem_access: RTL and testbench
==================================

# sram_mem_access

Multi-cycle data-memory access controller for the MEM stage of the 32-bit ARM pipeline. It receives the load/store request from the EXE/MEM pipeline register (`mem_r_en`, `mem_w_en`, `alu_res`, `val_rm`) and runs it as two 16-bit half-word transactions on an external asynchronous SRAM. It returns the 32-bit load result to the MEM/WB register and drives `ready`; the hazard/freeze logic holds all pipeline registers while `ready` is low.

## Interface

**Parameters**
- `WORD_WIDTH`, 32: pipeline word width.
- `SRAM_ADDR_WIDTH`, 18: SRAM half-word address width.
- `SRAM_DATA_WIDTH`, 16: SRAM data width. Fixed at `WORD_WIDTH/2`.
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 1: extra cycles per half-word phase. Must be ≥1.

**Ports**
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_r_en` in 1: load request.
- `mem_w_en` in 1: store request.
- `alu_res` in 32: byte address.
- `val_rm` in 32: store data.
- `ready` out 1: 1 = pipeline may advance this cycle.
- `res_data` out 32: load result.
- `sram_addr` out 18: half-word address.
- `sram_dq_out` out 16: write data.
- `sram_dq_in` in 16: read data.
- `sram_dq_oe` out 1: 1 = drive `sram_dq_out` onto the bus (tristate is at the top level).
- `sram_we_n` out 1: write strobe, active-low.
- `sram_oe_n` out 1: output enable, active-low.

## Operation

**Address mapping**
- `off = {alu_res[31:2],2'b00} - BASE_ADDR`, computed modulo 2^32.
- Word index `w = off[31:2]`.
- Low half (`[15:0]`) is at `sram_addr = {w,1'b0}`; high half (`[31:16]`) is at `{w,1'b1}`.
- Bits above `SRAM_ADDR_WIDTH` are truncated, so addresses wrap.

**Request decode**
- A request is `mem_r_en | mem_w_en`.
- If both are set, the request is a store and `res_data` stays 0.

**FSM states**
- **IDLE**
  - On a request: latch op, `w` and `val_rm`; load counter with `WAIT_CYCLES`; go to LO.
  - Otherwise: stay in IDLE.
- **LO**
  - Drive the low-half address.
  - Store: `sram_dq_oe=1`, `sram_dq_out=val_rm[15:0]`, and `sram_we_n=0` while counter≠0.
  - Load: `sram_oe_n=0`.
  - Counter decrements each cycle.
  - At counter==0: a load captures `sram_dq_in` into `lo`; reload counter; go to HI.
- **HI**
  - Same as LO, using the high-half address and `val_rm[31:16]`; a load captures into `hi`.
  - At counter==0: go to DONE.
- **DONE**
  - All strobes inactive.
  - Go to IDLE unconditionally.

**Outputs**
- `ready = ~(mem_r_en|mem_w_en) | (state==DONE)`, combinational.
- `res_data = (state==DONE && op==load) ? {hi,lo} : 0`.
- The pipeline advances on the DONE edge, so IDLE samples the next instruction's request on the following cycle.
- Address and data are taken from latched copies. Input changes after IDLE have no effect.

## Timing

**Reset values** (`rst=0`; take effect immediately, without waiting for a clock edge)
- state = IDLE.
- `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`.
- `sram_addr=0`, `sram_dq_out=0`, `lo=hi=0`, counter=0.
- `res_data=0`.
- `ready` follows its combinational equation, so it is 1 with no request.

**Latency**, with N = `WAIT_CYCLES`
- 1 IDLE cycle + (N+1) LO cycles + (N+1) HI cycles.
- `ready` is low for 2N+3 cycles, then high for exactly 1 cycle (DONE).
- With N=1: ready low for cycles 1–5, high on cycle 6.

**Strobe timing**
- Each phase is N+1 cycles long.
- `sram_we_n` is low for the first N cycles of a phase and high in its last cycle. Address and data are stable for the whole phase, which gives setup and hold margin.
- A load samples `sram_dq_in` on the rising edge that ends the last cycle of the phase.

**Pipeline interaction**
- Back-to-back requests are separated only by the IDLE cycle; there is no additional bubble.
- No request means the pipeline runs at full rate: `ready=1`, strobes inactive.

**Reset mid-transaction**
- The access is aborted and strobes are released at once.
- A store interrupted in HI leaves the low half written and the high half unwritten. This is acceptable.

## Test plan

1. **Reset:** `rst=0`, no request → `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`, `res_data=0`, `ready=1`.
2. **Store, N=1:** `alu_res=1024`, `val_rm=0xDEADBEEF`, `mem_w_en=1` → `sram_addr=0` with dq 0xBEEF for 2 cycles (`we_n` low in the first), then `sram_addr=1` with dq 0xDEAD likewise; `ready` low for cycles 1–5 and high on cycle 6; `res_data=0`.
3. **Load, unaligned address:** `alu_res=1026`, `mem_r_en=1`, SRAM model holding test 2 data → `res_data=0xDEADBEEF` only in the DONE cycle; 0 before and after.
4. **Both enables set:** `mem_r_en=mem_w_en=1`, `alu_res=1044`, `val_rm=0x12345678` → store to `sram_addr` 10/11 (0x5678/0x1234); `res_data` stays 0.
5. **Reset mid-transaction:** assert `rst=0` during the HI phase of a store → strobes inactive immediately and state IDLE. A following load of `alu_res=1024` completes in 6 cycles.
6. **Back-to-back:** a load followed by a store presented on the cycle after DONE → the second transaction's IDLE cycle immediately follows DONE; the total for both is 12 cycles (N=1).

Source files
------------

// File: rtl/sram_mem_access.sv
// sram_mem_access
// MEM-stage data-memory access controller. A 32-bit load or store from the
// EXE/MEM register is carried out as two 16-bit half-word transactions on an
// external asynchronous SRAM: low half first, then high half. Each phase lasts
// WAIT_CYCLES+1 cycles. The write strobe is held low for all but the last
// cycle of a phase, so address and data stay stable on both sides of the
// strobe.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   mem_r_en     load request
//   mem_w_en     store request (wins if both enables are set)
//   alu_res      byte address
//   val_rm       store data
//   ready        1 = pipeline may advance this cycle
//   res_data     load result, valid only in the DONE cycle (0 otherwise)
//   sram_addr    half-word address
//   sram_dq_out  write data
//   sram_dq_in   read data
//   sram_dq_oe   1 = drive sram_dq_out onto the bus
//   sram_we_n    write strobe, active-low
//   sram_oe_n    output enable, active-low
module sram_mem_access #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int BASE_ADDR       = 1024,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_r_en,
  input  logic                       mem_w_en,
  input  logic [WORD_WIDTH-1:0]      alu_res,
  input  logic [WORD_WIDTH-1:0]      val_rm,
  output logic                       ready,
  output logic [WORD_WIDTH-1:0]      res_data,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_dq_oe,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t                       state;
  logic                         op_load;
  logic [SRAM_ADDR_WIDTH-2:0]   widx_q;
  logic [SRAM_DATA_WIDTH-1:0]   wdata_hi_q;
  logic [CNT_W-1:0]             cnt;
  logic [SRAM_DATA_WIDTH-1:0]   lo;
  logic [SRAM_DATA_WIDTH-1:0]   hi;

  logic                         req;
  logic [WORD_WIDTH-1:0]        off;
  logic [SRAM_ADDR_WIDTH-2:0]   word_idx;
  logic                         unused_bits;

  assign req = mem_r_en | mem_w_en;

  // Byte offset from the SRAM window base, wrapping modulo 2^32; only the
  // word-index bits that fit the SRAM address survive.
  assign off         = {alu_res[WORD_WIDTH-1:2], 2'b00} - WORD_WIDTH'(BASE_ADDR);
  assign word_idx    = off[SRAM_ADDR_WIDTH:2];
  assign unused_bits = ^{off[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], off[1:0], alu_res[1:0]};

  assign ready    = ~req | (state == S_DONE);
  assign res_data = (state == S_DONE && op_load) ? {hi, lo} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_load     <= 1'b0;
      widx_q      <= '0;
      wdata_hi_q  <= '0;
      cnt         <= '0;
      lo          <= '0;
      hi          <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            // Strobes for the LO phase are set up here so they are registered
            // and valid from the first LO cycle.
            op_load     <= mem_r_en & ~mem_w_en;
            widx_q      <= word_idx;
            wdata_hi_q  <= val_rm[WORD_WIDTH-1:SRAM_DATA_WIDTH];
            cnt         <= CNT_LOAD;
            state       <= S_LO;
            sram_addr   <= {word_idx, 1'b0};
            sram_dq_out <= val_rm[SRAM_DATA_WIDTH-1:0];
            sram_dq_oe  <= mem_w_en;
            sram_we_n   <= ~mem_w_en;
            sram_oe_n   <= ~(mem_r_en & ~mem_w_en);
          end
        end
        S_LO: begin
          if (cnt == '0) begin
            if (op_load) lo <= sram_dq_in;
            cnt         <= CNT_LOAD;
            state       <= S_HI;
            sram_addr   <= {widx_q, 1'b1};
            sram_dq_out <= wdata_hi_q;
            sram_we_n   <= op_load;
          end else begin
            cnt <= cnt - CNT_W'(1);
            // Release the write strobe one cycle before the phase ends.
            if (cnt == CNT_W'(1)) sram_we_n <= 1'b1;
          end
        end
        S_HI: begin
          if (cnt == '0) begin
            if (op_load) hi <= sram_dq_in;
            state      <= S_DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) sram_we_n <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_access.sv
module tb_sram_mem_access;

  localparam int N = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic        ready;
  logic [31:0] res_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit [15:0] sram [0:262143];
  bit [31:0] ref_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: a write lands while we_n is low; reads are combinational.
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = !sram_oe_n ? sram[sram_addr] : 16'h0000;

  sram_mem_access #(
    .WORD_WIDTH(32), .SRAM_ADDR_WIDTH(18), .SRAM_DATA_WIDTH(16),
    .BASE_ADDR(1024), .WAIT_CYCLES(N)
  ) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .ready(ready), .res_data(res_data),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word index in the SRAM for a byte address: aligned offset from base, wrapped.
  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a & 32'hFFFF_FFFC) - 32'd1024;
    return int'((o >> 2) & 32'h0001_FFFF);
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".we_n"}, 32'(sram_we_n), 32'd1);
    check({tag, ".oe_n"}, 32'(sram_oe_n), 32'd1);
    check({tag, ".dq_oe"}, 32'(sram_dq_oe), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      alu_res = $urandom;
      val_rm  = $urandom;
      @(negedge clk);
      check("idle.ready", 32'(ready), 32'd1);
      check("idle.res", res_data, 32'h0);
      check_quiet("idle");
      @(posedge clk); #1;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge. Cycle k=1 is the IDLE
  // cycle, then N+1 low-half cycles, N+1 high-half cycles and the DONE cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input string tag);
    int          idx;
    int          last;
    int          pk;
    bit          is_load;
    bit          hi_ph;
    logic [31:0] expv;
    logic [31:0] exp_addr;
    idx     = widx(addr);
    is_load = rd && !wr;
    expv    = ref_read(idx);
    last    = 2 * N + 4;
    mem_r_en = rd;
    mem_w_en = wr;
    alu_res  = addr;
    val_rm   = data;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check({tag, ".ready"}, 32'(ready), 32'(k == last));
      check({tag, ".res"}, res_data, (k == last && is_load) ? expv : 32'h0);
      if (k >= 2 && k < last) begin
        hi_ph    = (k >= N + 3);
        pk       = hi_ph ? k - (N + 3) : k - 2;
        exp_addr = hi_ph ? 32'(idx * 2 + 1) : 32'(idx * 2);
        check({tag, ".addr"}, 32'(sram_addr), exp_addr);
        check({tag, ".we_n"}, 32'(sram_we_n), (wr && pk < N) ? 32'd0 : 32'd1);
        check({tag, ".oe_n"}, 32'(sram_oe_n), is_load ? 32'd0 : 32'd1);
        check({tag, ".dq_oe"}, 32'(sram_dq_oe), 32'(wr));
        if (wr) check({tag, ".dq_out"}, 32'(sram_dq_out),
                      hi_ph ? 32'(data[31:16]) : 32'(data[15:0]));
      end else begin
        check_quiet(tag);
      end
      @(posedge clk); #1;
      // Address/data changes after the request is taken must be ignored.
      if (k == 1) begin
        alu_res = $urandom;
        val_rm  = $urandom;
      end
    end
    if (wr) ref_mem[idx] = data;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  initial begin
    int          c0;
    int          op;
    logic [31:0] a;
    logic [31:0] d;

    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; val_rm = '0;

    // Reset takes effect without a clock edge.
    #2 rst = 1'b0;
    #1;
    check_quiet("rst");
    check("rst.res", res_data, 32'h0);
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.addr", 32'(sram_addr), 32'h0);
    check("rst.dq_out", 32'(sram_dq_out), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    // Store then unaligned load of the same word.
    run_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "store");
    run_txn(1'b1, 1'b0, 32'd1026, 32'h0, "load_unal");
    idle_cycles(1);

    // Both enables: treated as a store.
    run_txn(1'b1, 1'b1, 32'd1044, 32'h12345678, "both");
    check("both.sram10", 32'(sram[10]), 32'h5678);
    check("both.sram11", 32'(sram[11]), 32'h1234);

    // Reset during the first high-half cycle of a store.
    d = $urandom;
    mem_w_en = 1'b1; alu_res = 32'd1024; val_rm = d;
    repeat (N + 2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_quiet("midrst");
    check("midrst.ready_req", 32'(ready), 32'd0);
    check("midrst.res", res_data, 32'h0);
    mem_w_en = 1'b0;
    #1;
    check("midrst.ready_idle", 32'(ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    ref_mem[0] = {ref_mem[0][31:16], d[15:0]};
    run_txn(1'b1, 1'b0, 32'd1024, 32'h0, "load_after_rst");

    // Back-to-back load then store: no bubble beyond the IDLE cycle.
    c0 = cyc;
    run_txn(1'b1, 1'b0, 32'd1044, 32'h0, "b2b_ld");
    run_txn(1'b0, 1'b1, 32'd1024 + 32'($urandom_range(0, 15) * 4), $urandom, "b2b_st");
    check("b2b.cycles", 32'(cyc - c0), 32'd12);
    idle_cycles(1);

    // Randomized mix in a small window plus addresses below base that wrap.
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 1023));
      else a = 32'd1024 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      run_txn(op != 1, op != 0, a, d, "rnd");
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
